// File: rtl/blake2b_core_seq.sv
// -----------------------------------------------------------------------------
// blake2b_core_seq
//
// Sequential single-block BLAKE2b hasher. It captures up to MSG_BYTES message
// bytes and hashes them as one final compression block. It evaluates one G
// function per clock and produces an OUT_BYTES digest.
//
// Parameters:
//   MSG_BYTES  message bus width in bytes (1..128)
//   OUT_BYTES  digest length in bytes (1..64)
//   ROUNDS     compression rounds (12 = standard BLAKE2b)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   hash request, sampled only in IDLE
//   msg       in   message, byte i at [8i+7:8i]
//   msg_len   in   valid byte count, clamped to MSG_BYTES
//   personal  in   128-bit personalisation {P1,P0} (only with BLAKE2B_PERSONAL_EN)
//   busy      out  high while a hash is in progress
//   done      out  one-cycle pulse when hash has been updated
//   hash      out  digest, digest byte 0 at the MSBs
//   state_o   out  debug view of the FSM state (0 IDLE,1 INIT,2 ROUND,3 FINAL)
//
// Optional feature macro: BLAKE2B_PERSONAL_EN adds the personal input and folds
// P0/P1 into h[6]/h[7] at INIT. Timing is the same in both builds.
//
// Handshake: start is accepted only while state is IDLE. busy is high from
// the cycle after the accepting edge through the FINAL cycle. done is a
// one-cycle pulse in the first IDLE cycle after FINAL, and hash is valid from
// that cycle until the next FINAL or reset. A start seen while busy is dropped.
// -----------------------------------------------------------------------------
module blake2b_core_seq #(
  parameter int MSG_BYTES = 80,
  parameter int OUT_BYTES = 32,
  parameter int ROUNDS    = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [MSG_BYTES*8-1:0] msg,
  input  logic [7:0]             msg_len,
`ifdef BLAKE2B_PERSONAL_EN
  input  logic [127:0]           personal,
`endif
  output logic                   busy,
  output logic                   done,
  output logic [OUT_BYTES*8-1:0] hash,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_INIT  = 2'd1,
    S_ROUND = 2'd2,
    S_FINAL = 2'd3
  } state_t;

  // IV7..IV0, word i at [64i+63:64i]
  localparam logic [511:0] IV = {
    64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b,
    64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
    64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b,
    64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908
  };

  // Message schedule: row r at [64r+63:64r], entry i of a row at nibble i.
  localparam logic [639:0] SIGMA = {
    64'h0DC3E9BF5167482A, 64'h5A417D2C803B9EF6,
    64'hA2684F05931CE7BD, 64'hB8293670A4DEF15C,
    64'h91EF57D438B0A6C2, 64'hD386CB1EFA427509,
    64'h8F04A562EBCD1397, 64'h491763EADF250C8B,
    64'h357B20C16DF984AE, 64'hFEDCBA9876543210
  };

  localparam logic [7:0] MSG_BYTES_L = 8'(MSG_BYTES);
  localparam logic [3:0] ROUND_LAST  = 4'(ROUNDS - 1);

  function automatic logic [63:0] rotr(input logic [63:0] w, input int n);
    return (w >> n) | (w << (64 - n));
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;

  logic [63:0]            v_q [16];
  logic [63:0]            v_d [16];
  logic [63:0]            h_q [8];
  logic [63:0]            h_d [8];
  logic [63:0]            m_q [16];
  logic [63:0]            m_d [16];
  logic [7:0]             len_q, len_d;
  logic [2:0]             step_q, step_d;
  logic [3:0]             round_q, round_d;
  logic [OUT_BYTES*8-1:0] hash_q, hash_d;
  logic                   done_q, done_d;
`ifdef BLAKE2B_PERSONAL_EN
  logic [127:0]           pers_q, pers_d;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register / next-state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_ROUND;
      S_ROUND: if (step_q == 3'd7 && round_q == ROUND_LAST) state_d = S_FINAL;
      S_FINAL: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    state_o = state_q;
    done    = done_q;
    hash    = hash_q;
  end

  // ---------------------------------------------------------------------------
  // Message capture: bytes at or beyond the clamped length read as zero.
  // ---------------------------------------------------------------------------
  logic [7:0]    len_clamp;
  logic [1023:0] msg_pad;
  logic [63:0]   m_cap [16];

  always_comb begin
    len_clamp = (msg_len > MSG_BYTES_L) ? MSG_BYTES_L : msg_len;
    msg_pad   = '0;
    msg_pad[MSG_BYTES*8-1:0] = msg;
    for (int w = 0; w < 16; w++) m_cap[w] = '0;
    for (int b = 0; b < 128; b++) begin
      if (8'(b) < len_clamp) m_cap[b/8][8*(b%8) +: 8] = msg_pad[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // One G function per clock. Steps 0..3 are columns, 4..7 diagonals; the
  // diagonal index of each row is (j + row) mod 4, done by 2-bit wraparound.
  // ---------------------------------------------------------------------------
  logic [3:0]  ia, ib, ic, id, r_mod, sx, sy;
  logic [1:0]  j;
  logic [9:0]  off_x, off_y;
  logic [63:0] a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    j = step_q[1:0];
    ia = {2'b00, j};
    if (!step_q[2]) begin
      ib = {2'b01, j};
      ic = {2'b10, j};
      id = {2'b11, j};
    end else begin
      ib = {2'b01, j + 2'd1};
      ic = {2'b10, j + 2'd2};
      id = {2'b11, j + 2'd3};
    end
    r_mod = (round_q >= 4'd10) ? (round_q - 4'd10) : round_q;
    off_x = {r_mod, 6'b0} + {4'b0, step_q, 1'b0, 2'b0};
    off_y = {r_mod, 6'b0} + {4'b0, step_q, 1'b1, 2'b0};
    sx    = SIGMA[off_x +: 4];
    sy    = SIGMA[off_y +: 4];

    a1 = v_q[ia] + v_q[ib] + m_q[sx];
    d1 = rotr(v_q[id] ^ a1, 32);
    c1 = v_q[ic] + d1;
    b1 = rotr(v_q[ib] ^ c1, 24);
    a2 = a1 + b1 + m_q[sy];
    d2 = rotr(d1 ^ a2, 16);
    c2 = c1 + d2;
    b2 = rotr(b1 ^ c2, 63);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    v_d     = v_q;
    h_d     = h_q;
    m_d     = m_q;
    len_d   = len_q;
    step_d  = step_q;
    round_d = round_q;
    hash_d  = hash_q;
    done_d  = 1'b0;
`ifdef BLAKE2B_PERSONAL_EN
    pers_d  = pers_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d   = m_cap;
          len_d = len_clamp;
`ifdef BLAKE2B_PERSONAL_EN
          pers_d = personal;
`endif
        end
      end
      S_INIT: begin
        for (int i = 0; i < 8; i++) h_d[i] = IV[64*i +: 64];
        // Parameter block word 0: digest length, key length 0, fanout 1, depth 1.
        h_d[0] = h_d[0] ^ 64'h0000_0000_0101_0000 ^ 64'(OUT_BYTES);
`ifdef BLAKE2B_PERSONAL_EN
        h_d[6] = h_d[6] ^ pers_q[63:0];
        h_d[7] = h_d[7] ^ pers_q[127:64];
`endif
        for (int i = 0; i < 8; i++) begin
          v_d[i]     = h_d[i];
          v_d[i + 8] = IV[64*i +: 64];
        end
        // Byte counter t0 = len, and the final-block flag.
        v_d[12] = v_d[12] ^ {56'b0, len_q};
        v_d[14] = ~v_d[14];
        step_d  = 3'd0;
        round_d = 4'd0;
      end
      S_ROUND: begin
        v_d[ia] = a2;
        v_d[ib] = b2;
        v_d[ic] = c2;
        v_d[id] = d2;
        step_d  = step_q + 3'd1;
        if (step_q == 3'd7) begin
          round_d = (round_q == ROUND_LAST) ? 4'd0 : (round_q + 4'd1);
        end
      end
      S_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] ^ v_q[i] ^ v_q[i + 8];
        // Little-endian bytes of h, first digest byte placed at the MSBs.
        for (int b = 0; b < OUT_BYTES; b++) begin
          hash_d[(OUT_BYTES-1-b)*8 +: 8] = h_d[b/8][8*(b%8) +: 8];
        end
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        v_q[i] <= '0;
        m_q[i] <= '0;
      end
      for (int i = 0; i < 8; i++) h_q[i] <= '0;
      len_q   <= '0;
      step_q  <= '0;
      round_q <= '0;
      hash_q  <= '0;
      done_q  <= 1'b0;
`ifdef BLAKE2B_PERSONAL_EN
      pers_q  <= '0;
`endif
    end else begin
      v_q     <= v_d;
      h_q     <= h_d;
      m_q     <= m_d;
      len_q   <= len_d;
      step_q  <= step_d;
      round_q <= round_d;
      hash_q  <= hash_d;
      done_q  <= done_d;
`ifdef BLAKE2B_PERSONAL_EN
      pers_q  <= pers_d;
`endif
    end
  end

endmodule

// File: tb/tb_blake2b_core_seq.sv
// -----------------------------------------------------------------------------
// tb_blake2b_core_seq
//
// Directed bench for blake2b_core_seq. It runs a default instance
// (80-byte message, 32-byte digest) and a wide instance (128-byte message,
// 64-byte digest). Both instances share start and msg_len.
// Expected digests are the published BLAKE2b-256/512 values.
// -----------------------------------------------------------------------------
module tb_blake2b_core_seq;

  localparam logic [255:0] H_ABC   = 256'hbddd813c634239723171ef3fee98579b94964e3bb1cb3e427262c8c068d52319;
  localparam logic [255:0] H_EMPTY = 256'h0e5751c026e543b2e8ab2eb06099daa1d1e5df47778f7787faab45cdf12fe3a8;
  localparam logic [511:0] H_ABC512 = 512'hba80a53f981c4d0d6a2797b69f12f6e94c212f14685ac4b74b12bb6fdbffa2d17d87c5392aab792dc252d5de4533cc9518d38aa8dbf1925ab92386edd4009923;
  localparam int LAT = 98;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUTs
  // ---------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [639:0]  msg;
  logic [1023:0] msg2;
  logic [7:0]    msg_len;
  logic          busy, done, busy2, done2;
  logic [255:0]  hash;
  logic [511:0]  hash2;
  logic [1:0]    state_o, state2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  blake2b_core_seq #(.MSG_BYTES(80), .OUT_BYTES(32), .ROUNDS(12)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg      (msg),
    .msg_len  (msg_len),
`ifdef BLAKE2B_PERSONAL_EN
    .personal (128'd0),
`endif
    .busy     (busy),
    .done     (done),
    .hash     (hash),
    .state_o  (state_o)
  );

  blake2b_core_seq #(.MSG_BYTES(128), .OUT_BYTES(64), .ROUNDS(12)) dut_wide (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .msg      (msg2),
    .msg_len  (msg_len),
`ifdef BLAKE2B_PERSONAL_EN
    .personal (128'd0),
`endif
    .busy     (busy2),
    .done     (done2),
    .hash     (hash2),
    .state_o  (state2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver / check tasks (all called just after a rising edge)
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [511:0] obs, input logic [511:0] other);
    checks++;
    assert (obs !== other) else begin
      errors++;
      $error("FAIL %s: observed %0h expected a value different from %0h", tag, obs, other);
    end
  endtask

  // Presents a message and pulses start for exactly one edge (edge N).
  task automatic kick(input logic [639:0] m, input logic [7:0] len);
    msg     = m;
    msg2    = {384'b0, m};
    msg_len = len;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  // Counts edges after edge N until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) return;
    end
    lat = -1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  logic [639:0] m_abc, m_pat, m80;
  logic [255:0] h80, dhash;
  int           lat, dcount, didx, n_done;
  int           d_at [2];

  initial begin
    m_abc = 640'h636261;
    m_pat = {20{32'hdeadbeef}};
    m80   = '0;
    for (int i = 0; i < 80; i++) m80[8*i +: 8] = 8'(i * 37 + 5);

    rst = 1'b1; start = 1'b0; msg = '0; msg2 = '0; msg_len = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy",  512'(busy),    512'(0));
    chk("reset_done",  512'(done),    512'(0));
    chk("reset_hash",  512'(hash),    512'(0));
    chk("reset_state", 512'(state_o), 512'(0));
    chk("reset_hash2", hash2,         512'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // "abc" on both instances
    kick(m_abc, 8'd3);
    chk("abc_busy_after_start", 512'(busy),    512'(1));
    chk("abc_state_init",       512'(state_o), 512'(1));
    wait_done(lat);
    chk("abc_latency",    512'(lat),   512'(LAT));
    chk("abc_hash",       512'(hash),  512'(H_ABC));
    chk("abc_busy_low",   512'(busy),  512'(0));
    chk("abc512_done",    512'(done2), 512'(1));
    chk("abc512_hash",    hash2,       H_ABC512);
    @(posedge clk);
    #1;
    chk("abc_done_pulse", 512'(done),  512'(0));
    chk("abc_hash_hold",  512'(hash),  512'(H_ABC));

    // Empty message with a non-zero bus that must be masked
    kick(m_pat, 8'd0);
    wait_done(lat);
    chk("empty_latency", 512'(lat),  512'(LAT));
    chk("empty_hash",    512'(hash), 512'(H_EMPTY));

    // Second start while busy is ignored
    msg = m_abc; msg2 = {384'b0, m_abc}; msg_len = 8'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dcount = 0; didx = -1; dhash = '0;
    for (int i = 1; i <= 160; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dcount++;
        didx  = i;
        dhash = hash;
      end
      if (i == 39) begin
        msg = m_pat; msg2 = {384'b0, m_pat}; msg_len = 8'd7; start = 1'b1;
      end
      if (i == 40) start = 1'b0;
    end
    chk("busy_start_done_count", 512'(dcount), 512'(1));
    chk("busy_start_done_edge",  512'(didx),   512'(LAT));
    chk("busy_start_hash",       512'(dhash),  512'(H_ABC));
    chk("busy_start_idle",       512'(busy),   512'(0));

    // start held high re-triggers every 99 cycles
    msg = m_abc; msg2 = {384'b0, m_abc}; msg_len = 8'd3; start = 1'b1;
    n_done = 0; d_at[0] = -1; d_at[1] = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        d_at[n_done] = i;
        n_done++;
        if (n_done == 2) begin
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    chk("held_done_count", 512'(n_done),           512'(2));
    chk("held_first_done", 512'(d_at[0]),          512'(99));
    chk("held_period",     512'(d_at[1] - d_at[0]), 512'(99));
    chk("held_hash",       512'(hash),             512'(H_ABC));
    @(posedge clk);
    #1;
    chk("held_release_idle", 512'(busy), 512'(0));

    // Length clamp: 200 behaves as 80; 79 must differ
    kick(m80, 8'd80);
    wait_done(lat);
    chk("len80_latency", 512'(lat), 512'(LAT));
    h80 = hash;
    chk_ne("len80_not_empty", 512'(h80), 512'(H_EMPTY));
    kick(m80, 8'd200);
    wait_done(lat);
    chk("len200_latency",     512'(lat),  512'(LAT));
    chk("len200_clamp_to_80", 512'(hash), 512'(h80));
    kick(m80, 8'd79);
    wait_done(lat);
    chk_ne("len79_differs", 512'(hash), 512'(h80));

    // Asynchronous reset in the middle of ROUND
    kick(m_abc, 8'd3);
    repeat (29) @(posedge clk);
    #1;
    chk("pre_reset_state", 512'(state_o), 512'(2));
    rst = 1'b1;
    #1;
    chk("async_rst_busy",  512'(busy),    512'(0));
    chk("async_rst_done",  512'(done),    512'(0));
    chk("async_rst_hash",  512'(hash),    512'(0));
    chk("async_rst_state", 512'(state_o), 512'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    dcount = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (done) dcount++;
    end
    chk("no_done_after_reset", 512'(dcount), 512'(0));
    kick(m_abc, 8'd3);
    wait_done(lat);
    chk("post_reset_latency", 512'(lat),  512'(LAT));
    chk("post_reset_hash",    512'(hash), 512'(H_ABC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
